// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer: op codes,
// FSM states and the default operand width.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_UMUL = 2'b00,
        OP_SMUL = 2'b01,
        OP_UDIV = 2'b10,
        OP_SDIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: shift-add for multiply (div_i=0)
// or restoring trial-subtract-and-shift for divide (div_i=1).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_s;
    logic           fits;

    always_comb begin
        // Multiply: the WIDTH+1-bit sum keeps the carry that shifts into hi
        sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        rem_s = {hi_i, lo_i[WIDTH-1]};
        fits  = (rem_s >= {1'b0, opnd_i});
        if (div_i) begin
            hi_o = fits ? WIDTH'(rem_s - {1'b0, opnd_i}) : rem_s[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], fits};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative UMULL/SMULL/UDIV/SDIV sequencer, one step per clock.
// Optional MULDIV_FLAGS_EN adds a registered {N,Z,C,V} flags output.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
`ifdef MULDIV_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    op_e              op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q, a_q;
    logic [WIDTH-1:0] res_lo_q, res_hi_q;
    logic             sign_res_q, sign_rem_q, div0_q, busy_q, done_q;
    logic [WIDTH-1:0] hi_d, lo_d, fix_lo_d, fix_hi_d;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
    assign a_mag  = op[0] ? abs_val(a) : a;
    assign b_mag  = op[0] ? abs_val(b) : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (op_q[1]),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .opnd_i (opnd_q),
        .hi_o   (hi_d),
        .lo_o   (lo_d)
    );

    // Sign correction and divide-by-zero override applied in FIX
    always_comb begin
        fix_hi_d = hi_q;
        fix_lo_d = lo_q;
        if (!op_q[1]) begin
            if (op_q == OP_SMUL && sign_res_q)
                {fix_hi_d, fix_lo_d} = -{hi_q, lo_q};
        end else if (div0_q) begin
            fix_lo_d = '0;
            fix_hi_d = a_q;
        end else if (op_q == OP_SDIV) begin
            if (sign_res_q) fix_lo_d = -lo_q;
            if (sign_rem_q) fix_hi_d = -hi_q;
        end
    end

`ifdef MULDIV_FLAGS_EN
    logic [3:0] flags_q;
    logic       flag_n, flag_z;
    assign flag_n = op_q[1] ? fix_lo_d[WIDTH-1] : fix_hi_d[WIDTH-1];
    assign flag_z = op_q[1] ? (fix_lo_d == '0) : ({fix_hi_d, fix_lo_d} == '0);
    assign flags  = flags_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_UMUL;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            a_q        <= '0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            sign_res_q <= 1'b0;
            sign_rem_q <= 1'b0;
            div0_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MULDIV_FLAGS_EN
            flags_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // Multiply: lo holds multiplier, opnd the multiplicand; divide: lo holds dividend
                op_q       <= op_e'(op);
                hi_q       <= '0;
                lo_q       <= op[1] ? a_mag : b_mag;
                opnd_q     <= op[1] ? b_mag : a_mag;
                a_q        <= a;
                sign_res_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                sign_rem_q <= op[0] & a[WIDTH-1];
                div0_q     <= op[1] & (b == '0);
                cnt_q      <= '0;
                busy_q     <= 1'b1;
                state_q    <= S_CALC;
            end
            case (state_q)
                S_CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_q <= S_FIX;
                end
                S_FIX: begin
                    res_lo_q <= fix_lo_d;
                    res_hi_q <= fix_hi_d;
`ifdef MULDIV_FLAGS_EN
                    flags_q  <= {flag_n, flag_z, 2'b00};
`endif
                    busy_q   <= 1'b0;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    if (!start) state_q <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed products/quotients, latency,
// start-while-busy, back-to-back start in DONE and reset abort.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result_lo, result_hi;
`ifdef MULDIV_FLAGS_EN
    logic [3:0]   flags;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
`ifdef MULDIV_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 2'b01;
        a     = 32'hA5A5_5A5A;
        b     = 32'h0000_0003;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
    endtask

    int lat, bcnt, seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_lo", 64'(result_lo), 64'd0);
        check("rst_hi", 64'(result_hi), 64'd0);

        // UMUL max * max
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("umul_lat", 64'(lat), 64'd34);
        check("umul_busy", 64'(bcnt), 64'd33);
        check("umul_hi", 64'(result_hi), 64'hFFFF_FFFE);
        check("umul_lo", 64'(result_lo), 64'h0000_0001);
`ifdef MULDIV_FLAGS_EN
        check("umul_flags", 64'(flags), 64'b1000);
`endif
        tick();
        check("done_pulse", 64'(done), 64'd0);
        check("umul_hold", 64'(result_lo), 64'h0000_0001);

        // SMUL -3 * 7
        launch(2'b01, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, bcnt);
        check("smul_hi", 64'(result_hi), 64'hFFFF_FFFF);
        check("smul_lo", 64'(result_lo), 64'hFFFF_FFEB);

        // SDIV -100 / 7
        launch(2'b11, 32'hFFFF_FF9C, 32'd7);
        wait_done(lat, bcnt);
        check("sdiv_q", 64'(result_lo), 64'hFFFF_FFF2);
        check("sdiv_r", 64'(result_hi), 64'hFFFF_FFFE);

        // UDIV by zero
        launch(2'b10, 32'h1234_5678, 32'd0);
        wait_done(lat, bcnt);
        check("div0_q", 64'(result_lo), 64'd0);
        check("div0_r", 64'(result_hi), 64'h1234_5678);
`ifdef MULDIV_FLAGS_EN
        check("div0_flags", 64'(flags), 64'b0100);
`endif

        // SDIV overflow case
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("sdiv_ovf_q", 64'(result_lo), 64'h8000_0000);
        check("sdiv_ovf_r", 64'(result_hi), 64'd0);

        // UDIV 100/7 with an ignored start at cycle 5
        launch(2'b10, 32'd100, 32'd7);
        lat = 0;
        repeat (4) begin tick(); lat++; end
        op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
        tick(); lat++;
        start = 1'b0;
        while (busy && lat < 100) begin tick(); lat++; end
        check("udiv_to_done_state", 64'(lat), 64'd33);
        check("udiv_q", 64'(result_lo), 64'd14);
        check("udiv_r", 64'(result_hi), 64'd2);
        // Back-to-back start while in DONE
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(lat, bcnt);
        check("b2b_lat", 64'(lat), 64'd34);
        check("b2b_lo", 64'(result_lo), 64'd42);
        check("b2b_hi", 64'(result_hi), 64'd0);

        // Reset during CALC aborts
        launch(2'b01, 32'hFFFF_FFFD, 32'd7);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_lo", 64'(result_lo), 64'd0);
        check("abort_hi", 64'(result_hi), 64'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (done) seen++;
        end
        check("abort_nodone", 64'(seen), 64'd0);
        launch(2'b00, 32'h0001_0000, 32'h0001_0000);
        wait_done(lat, bcnt);
        check("post_lat", 64'(lat), 64'd34);
        check("post_hi", 64'(result_hi), 64'd1);
        check("post_lo", 64'(result_lo), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
